arith_extend_arbiter: RTL and testbench
=======================================

ARITH_EXTEND_ARBITER -- requirements
Module: Arith_extend_arbiter

Interface
REQ-001 Parameter IN_W, default 16, SHALL set the width of request operands.
REQ-002 Parameter OUT_W, default 32, SHALL set the width of extended results and SHALL be greater than or equal to IN_W.
REQ-003 Parameter REQS, default 2, SHALL set the number of requesters, range 2..8.
REQ-004 Parameter LAT, default 2, SHALL set the accept-to-response latency in cycles, minimum 1.
REQ-005 Port ctrl, input, Util_Control_T, SHALL carry ctrl.clock, the one clock, and ctrl.reset, the asynchronous active-high reset.
REQ-006 Port req_valid, input, [REQS], SHALL mark each requester as holding a valid operand.
REQ-007 Port req_data, input, [REQS] x IN_W, SHALL carry the per-requester operand.
REQ-008 Port req_sign, input, [REQS] x Arith_SignedUnsigned_T, SHALL carry the per-requester extension mode.
REQ-009 Port req_ready, output, [REQS], SHALL assert for the requester whose operand is accepted this cycle.
REQ-010 Port rsp_valid, output, [REQS], SHALL pulse for the requester whose result is presented this cycle.
REQ-011 Port rsp_data, output, OUT_W, SHALL carry the shared result bus, meaningful only while some rsp_valid bit is set.
REQ-012 Port busy, output, 1, SHALL assert while any accepted operation is still in flight.

Function
REQ-013 At most one request SHALL be accepted per cycle; accept = req_valid[i] && req_ready[i].
REQ-014 req_ready SHALL be one-hot or zero, SHALL depend combinationally on req_valid and the priority pointer, and SHALL never assert for a requester whose req_valid is low.
REQ-015 Arbitration SHALL be round-robin: the search starts at index ptr, and the lowest index at or after ptr (with wrap modulo REQS) that has valid set wins.
REQ-016 On an accept by index g, ptr SHALL become (g+1) mod REQS at the next edge; with no accept, ptr SHALL hold.
REQ-017 The accepted data, sign and requester id SHALL enter a LAT-stage delay line together with a valid bit, and all stages SHALL advance every cycle.
REQ-018 rsp_valid[id] SHALL assert exactly LAT cycles after the accept edge, for exactly one cycle.
REQ-019 rsp_data SHALL equal the operand sign-extended (Signed) or zero-extended (Unsigned) to OUT_W.
REQ-020 Throughput SHALL be one operation per cycle, and back-to-back accepts SHALL produce back-to-back responses in accept order.
REQ-021 There SHALL be no response backpressure; a requester SHALL sample the response in its rsp_valid cycle.
REQ-022 When rsp_valid is all zero, rsp_data SHALL be driven to 0.
REQ-023 busy SHALL be the OR of all delay-line valid bits.
REQ-024 A requester holding valid with other requesters also active SHALL be granted within REQS cycles.
REQ-025 A requester dropping req_valid before it is granted SHALL be legal, and the operand SHALL be discarded with no response.

Reset
REQ-026 While ctrl.reset is high, ptr SHALL be 0, all delay-line valid bits SHALL be 0, and rsp_valid, req_ready, busy and rsp_data SHALL all be 0, asynchronously.
REQ-027 Operations in flight when reset asserts SHALL be dropped and SHALL never produce a response.
REQ-028 The first accept after reset deassertion SHALL be possible on the first rising edge, with ptr at 0.

Structure
REQ-029 Arith_SignedUnsigned_T and its constants SHALL come from the shared Arith package.
REQ-030 Util_Control_T SHALL come from the shared Util package, and the block SHALL add no new package types.
REQ-031 The extension SHALL be performed by one instance of Arith_extend (IN_W, OUT_W, one lane) on the final delay-line stage.
REQ-032 The arbiter, pointer and delay line SHALL remain in this module.

Verification
REQ-033 Scenario single request (IN_W=4, OUT_W=8, LAT=2): req 0 valid with data 4'ha and Signed -> ready[0] asserts in the same cycle, and 2 cycles later rsp_valid[0]=1 with rsp_data=8'hfa.
REQ-034 Scenario unsigned extension: req 1 with data 4'ha and Unsigned -> rsp_data=8'h0a on rsp_valid[1].
REQ-035 Scenario fairness: both requesters held valid for 4 cycles starting with ptr=0 -> grants 0,1,0,1, and responses 0,1,0,1 on consecutive cycles after LAT.
REQ-036 Scenario wrap-around: REQS=3, ptr=2, requesters 0 and 2 both valid -> grant 2 first, then 0.
REQ-037 Scenario reset mid-flight: accept, then assert reset for 1 cycle before LAT elapses -> no rsp_valid ever appears, busy=0, and ptr=0.
REQ-038 Scenario withdrawal: req 1 asserts valid while req 0 is granted, then drops it -> no grant and no response for requester 1.

Source files
------------

// File: rtl/Arith.sv
`default_nettype none
// ============================================================================
//  Package : Arith
//  Shared arithmetic types.
//    Arith_SignedUnsigned_T : selects sign- or zero-extension of an operand
//  Revision: 1.0  initial release
// ============================================================================
package Arith;

  typedef enum logic {
    Arith_Unsigned = 1'b0,
    Arith_Signed   = 1'b1
  } Arith_SignedUnsigned_T;

endpackage
`default_nettype wire

// File: rtl/Util.sv
`default_nettype none
// ============================================================================
//  Package : Util
//  Shared utility types used across blocks.
//    Util_Control_T : bundled clock and asynchronous active-high reset
//  Revision: 1.0  initial release
// ============================================================================
package Util;

  typedef struct packed {
    logic clock;
    logic reset;
  } Util_Control_T;

endpackage
`default_nettype wire

// File: rtl/arith_extend_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Package : arith_extend_arbiter_pkg
//  Helpers local to the arbiter. Holds no types; shared types come from the
//  Arith and Util packages.
//    rr_index : requester index visited at a given offset from the pointer
//  Revision: 1.0  initial release
// ============================================================================
package arith_extend_arbiter_pkg;

  // Index of the requester examined 'offset' steps after 'base', wrapping at n.
  function automatic int rr_index(input int base, input int offset, input int n);
    return (base + offset) % n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/Arith_extend.sv
`default_nettype none
// ============================================================================
//  Module  : Arith_extend
//  Per-lane sign or zero extension of IN_W-bit operands to OUT_W bits.
//  Ports:
//    i_data : LANES x IN_W operands
//    i_sign : LANES extension modes (Arith_Signed / Arith_Unsigned)
//    o_data : LANES x OUT_W extended results
//  Revision: 1.0  initial release
// ============================================================================
module Arith_extend
  import Arith::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int LANES = 1
) (
  input  logic                  [LANES-1:0][IN_W-1:0]  i_data,
  input  Arith_SignedUnsigned_T [LANES-1:0]            i_sign,
  output logic                  [LANES-1:0][OUT_W-1:0] o_data
);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    if (OUT_W == IN_W) begin : g_same
      assign o_data[l] = i_data[l];
    end else begin : g_ext
      logic w_fill;
      // Fill bit is the operand MSB only when sign-extending.
      assign w_fill    = (i_sign[l] == Arith_Signed) & i_data[l][IN_W-1];
      assign o_data[l] = {{(OUT_W-IN_W){w_fill}}, i_data[l]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/arith_extend_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : arith_extend_arbiter
//  Round-robin arbiter in front of a LAT-stage pipeline that sign/zero
//  extends the granted operand and returns it to the granted requester.
//  Ports:
//    ctrl      : clock and asynchronous active-high reset
//    req_valid : per-requester operand valid
//    req_data  : per-requester IN_W operand
//    req_sign  : per-requester extension mode
//    req_ready : one-hot (or zero) accept strobe, combinational
//    rsp_valid : one-hot (or zero) response strobe, LAT cycles after accept
//    rsp_data  : shared OUT_W result bus, zero when no response
//    busy      : any operation in flight
//  Revision: 1.0  initial release
// ============================================================================
module arith_extend_arbiter
  import Arith::*;
  import Util::*;
  import arith_extend_arbiter_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int REQS  = 2,
  parameter int LAT   = 2
) (
  input  Util_Control_T                           ctrl,
  input  logic                  [REQS-1:0]            req_valid,
  input  logic                  [REQS-1:0][IN_W-1:0]  req_data,
  input  Arith_SignedUnsigned_T [REQS-1:0]            req_sign,
  output logic                  [REQS-1:0]            req_ready,
  output logic                  [REQS-1:0]            rsp_valid,
  output logic                  [OUT_W-1:0]           rsp_data,
  output logic                                        busy
);

  localparam int ID_W = $clog2(REQS);

  logic w_clk;
  logic w_rst;
  assign w_clk = ctrl.clock;
  assign w_rst = ctrl.reset;

  // ---------------------------------------------------------------- arbiter
  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] w_idx;
  logic [ID_W-1:0] w_gnt_id;
  logic [ID_W-1:0] w_ptr_nxt;
  logic            w_gnt_any;
  logic            w_accept;

  // First valid requester at or after r_ptr, wrapping modulo REQS.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_id  = '0;
    w_idx     = '0;
    for (int k = 0; k < REQS; k++) begin
      w_idx = ID_W'(rr_index(int'(r_ptr), k, REQS));
      if (!w_gnt_any && req_valid[w_idx]) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = w_idx;
      end
    end
  end

  // Reset masks the grant so nothing is accepted while reset is held.
  assign w_accept  = w_gnt_any && !w_rst;
  assign req_ready = w_accept ? (REQS'(1) << w_gnt_id) : '0;
  assign w_ptr_nxt = (w_gnt_id == ID_W'(REQS-1)) ? '0 : w_gnt_id + ID_W'(1);

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_ptr <= '0;
    end else if (w_accept) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  // ------------------------------------------------------------- delay line
  logic [LAT-1:0]            r_vld;
  logic [LAT-1:0][IN_W-1:0]  r_dat;
  logic [LAT-1:0]            r_sgn;
  logic [LAT-1:0][ID_W-1:0]  r_id;

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_vld <= '0;
      r_dat <= '0;
      r_sgn <= '0;
      r_id  <= '0;
    end else begin
      r_vld[0] <= w_accept;
      r_dat[0] <= req_data[w_gnt_id];
      r_sgn[0] <= req_sign[w_gnt_id];
      r_id[0]  <= w_gnt_id;
      for (int i = 1; i < LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_dat[i] <= r_dat[i-1];
        r_sgn[i] <= r_sgn[i-1];
        r_id[i]  <= r_id[i-1];
      end
    end
  end

  // ------------------------------------------------------ extension + output
  logic [OUT_W-1:0] w_ext;

  Arith_extend #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .LANES (1)
  ) u_ext (
    .i_data (r_dat[LAT-1]),
    .i_sign (Arith_SignedUnsigned_T'(r_sgn[LAT-1])),
    .o_data (w_ext)
  );

  assign rsp_valid = r_vld[LAT-1] ? (REQS'(1) << r_id[LAT-1]) : '0;
  assign rsp_data  = r_vld[LAT-1] ? w_ext : '0;
  assign busy      = |r_vld;

endmodule
`default_nettype wire

// File: tb/tb_arith_extend_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_arith_extend_arbiter
//  Scoreboard bench: directed stimulus pushes expected responses, a monitor
//  pops and compares whenever rsp_valid is seen.
//  DUT configured IN_W=4, OUT_W=8, REQS=3, LAT=2.
//  Revision: 1.0  initial release
// ============================================================================
module tb_arith_extend_arbiter;
  import Arith::*;
  import Util::*;

  localparam int LAT = 2;

  typedef struct {
    int         id;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic                            clk = 1'b0;
  logic                            rst = 1'b1;
  Util_Control_T                   ctrl;
  logic [2:0]                      req_valid = '0;
  logic [2:0][3:0]                 req_data  = '0;
  Arith_SignedUnsigned_T [2:0]     req_sign;
  logic [2:0]                      req_ready;
  logic [2:0]                      rsp_valid;
  logic [7:0]                      rsp_data;
  logic                            busy;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  assign ctrl = '{clock: clk, reset: rst};

  arith_extend_arbiter #(
    .IN_W  (4),
    .OUT_W (8),
    .REQS  (3),
    .LAT   (LAT)
  ) dut (
    .ctrl      (ctrl),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_sign  (req_sign),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_sign(input logic [2:0] s);
    for (int i = 0; i < 3; i++)
      req_sign[i] = s[i] ? Arith_Signed : Arith_Unsigned;
  endtask

  // One cycle of stimulus: drive, check grant, and queue the expected response.
  task automatic step(input string name, input logic [2:0] v,
                      input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                      input logic [2:0] s, input logic [2:0] exp_rdy,
                      input logic [7:0] exp_d, input bit push);
    exp_t e;
    @(posedge clk);
    #1;
    req_valid   = v;
    req_data[0] = d0;
    req_data[1] = d1;
    req_data[2] = d2;
    set_sign(s);
    @(negedge clk);
    chk({name, "_ready"}, {5'b0, req_ready}, {5'b0, exp_rdy});
    if (push) begin
      e.id   = exp_rdy[2] ? 2 : (exp_rdy[1] ? 1 : 0);
      e.data = exp_d;
      e.cyc  = cyc + LAT;
      sb.push_back(e);
    end
  endtask

  // Monitor: every response must match the head of the scoreboard, in order
  // and with exact latency; bus must be zero when idle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid != 3'b000) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_rsp: rsp_valid=%b rsp_data=%h, required no response (cycle %0d)",
                   rsp_valid, rsp_data, cyc);
        end else begin
          e = sb.pop_front();
          if (rsp_valid !== (3'b001 << e.id) || rsp_data !== e.data || cyc != e.cyc) begin
            n_fail++;
            $display("FAIL rsp: rsp_valid=%b data=%h cycle=%0d, required id=%0d data=%h cycle=%0d",
                     rsp_valid, rsp_data, cyc, e.id, e.data, e.cyc);
          end
        end
      end else begin
        chk("idle_rsp_data", rsp_data, 8'h00);
      end
    end
  end

  initial begin
    set_sign(3'b000);
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {5'b0, req_ready}, 8'h00);
    chk("rst_rsp_valid", {5'b0, rsp_valid}, 8'h00);
    chk("rst_busy", {7'b0, busy}, 8'h00);
    chk("rst_rsp_data", rsp_data, 8'h00);
    rst = 1'b0;

    // Single signed request, first edge after reset
    step("single", 3'b001, 4'ha, 4'h0, 4'h0, 3'b001, 3'b001, 8'hfa, 1'b1);
    step("idle", 3'b000, 4'h0, 4'h0, 4'h0, 3'b000, 3'b000, 8'h00, 1'b0);
    chk("busy_inflight", {7'b0, busy}, 8'h01);
    // Unsigned extension on requester 1
    step("unsigned", 3'b010, 4'h0, 4'ha, 4'h0, 3'b000, 3'b010, 8'h0a, 1'b1);
    // Bring pointer back to 0
    step("ptr_to0", 3'b100, 4'h0, 4'h0, 4'h5, 3'b100, 3'b100, 8'h05, 1'b1);
    // Fairness: 0 and 1 held valid
    step("fair_a", 3'b011, 4'h8, 4'h7, 4'h0, 3'b011, 3'b001, 8'hf8, 1'b1);
    step("fair_b", 3'b011, 4'h8, 4'h7, 4'h0, 3'b011, 3'b010, 8'h07, 1'b1);
    step("fair_c", 3'b011, 4'h3, 4'hf, 4'h0, 3'b000, 3'b001, 8'h03, 1'b1);
    step("fair_d", 3'b011, 4'h3, 4'hf, 4'h0, 3'b000, 3'b010, 8'h0f, 1'b1);
    // Wrap-around: ptr=2, requesters 0 and 2 valid
    step("wrap_a", 3'b101, 4'h1, 4'h0, 4'h9, 3'b101, 3'b100, 8'hf9, 1'b1);
    step("wrap_b", 3'b101, 4'h1, 4'h0, 4'h9, 3'b101, 3'b001, 8'h01, 1'b1);
    // Withdrawal: ptr to 0, then req 1 raised while 0 wins, then dropped
    step("wd_ptr", 3'b100, 4'h0, 4'h0, 4'hc, 3'b000, 3'b100, 8'h0c, 1'b1);
    step("wd_grant0", 3'b011, 4'h6, 4'h3, 4'h0, 3'b001, 3'b001, 8'h06, 1'b1);
    step("wd_drop", 3'b000, 4'h0, 4'h0, 4'h0, 3'b000, 3'b000, 8'h00, 1'b0);
    chk("wd_busy", {7'b0, busy}, 8'h01);

    // Reset mid-flight: accept req 1 (ptr -> 2), then reset before LAT elapses
    step("rmf_accept", 3'b010, 4'h0, 4'h4, 4'h0, 3'b010, 3'b010, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    req_valid = 3'b101;
    @(negedge clk);
    chk("rmf_ready", {5'b0, req_ready}, 8'h00);
    chk("rmf_rsp_valid", {5'b0, rsp_valid}, 8'h00);
    chk("rmf_busy", {7'b0, busy}, 8'h00);
    chk("rmf_rsp_data", rsp_data, 8'h00);
    rst       = 1'b0;
    req_valid = 3'b000;
    // Pointer must be back at 0: requester 0 wins over 2
    step("rmf_ptr0", 3'b101, 4'h2, 4'h0, 4'he, 3'b101, 3'b001, 8'h02, 1'b1);
    step("drain", 3'b000, 4'h0, 4'h0, 4'h0, 3'b000, 3'b000, 8'h00, 1'b0);

    repeat (LAT + 3) @(negedge clk);
    chk("sb_empty", 8'(sb.size()), 8'h00);
    chk("final_busy", {7'b0, busy}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
